// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding and divide constants for muldiv_sequencer.
// Build option: define MULDIV_MADD_EN to make MADD/MSUB legal ops.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MADD  = 3'd4,
      OP_MSUB  = 3'd5
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL_WAIT,
      S_DIV_RUN,
      S_DIV_FIXUP,
      S_DONE
   } state_e;

   localparam int DIV_ITER = 32;

   function automatic logic is_legal_op(input logic [2:0] op);
      case (op)
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: return 1'b1;
`ifdef MULDIV_MADD_EN
         OP_MADD, OP_MSUB:                   return 1'b1;
`endif
         default:                            return 1'b0;
      endcase
   endfunction

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// One restoring-divide iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step (
   input  logic [31:0] rem_i,
   input  logic        dividend_bit_i,
   input  logic [31:0] divisor_i,
   output logic [31:0] rem_o,
   output logic        quo_bit_o
);

   logic [32:0] shifted;

   // The partial remainder is always below the divisor, so 33 bits suffice.
   assign shifted   = {rem_i, dividend_bit_i};
   assign quo_bit_o = (shifted >= {1'b0, divisor_i});
   assign rem_o     = quo_bit_o ? 32'(shifted - {1'b0, divisor_i}) : shifted[31:0];

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle HI/LO sequencer: fixed-latency multiply, 32-step restoring divide.
// Build option: define MULDIV_MADD_EN to enable MADD/MSUB accumulation.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int MULT_LATENCY = 4,
   parameter int DIV_ITER     = muldiv_pkg::DIV_ITER
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        StartIn,
   input  logic [2:0]  OpIn,
   input  logic [31:0] OperandAIn,
   input  logic [31:0] OperandBIn,
   input  logic [31:0] HiIn,
   input  logic [31:0] LoIn,
   input  logic        FlushIn,
   output logic        BusyOut,
   output logic        StallOut,
   output logic        DoneOut,
   output logic        HiLoWriteOut,
   output logic        DivByZeroOut,
   output logic [31:0] HiOut,
   output logic [31:0] LoOut
);

   localparam logic [4:0] MUL_CNT_INIT = 5'(MULT_LATENCY - 1);
   localparam logic [4:0] DIV_CNT_INIT = 5'(DIV_ITER - 1);

   state_e      state_q;
   logic [2:0]  op_q;
   logic [4:0]  cnt_q;
   logic [31:0] a_q;          // multiplicand, or dividend shifting out / quotient shifting in
   logic [31:0] b_q;
   logic [31:0] rem_q;
   logic        quo_neg_q, rem_neg_q, dbz_q;
   logic        busy_q, done_q, write_q, dbz_out_q;
   logic [31:0] hi_q, lo_q;
`ifdef MULDIV_MADD_EN
   logic [63:0] acc_q;
`else
   logic        unused_hilo;
   assign unused_hilo = ^{HiIn, LoIn};
`endif

   logic        accept, a_neg, b_neg;
   logic [31:0] abs_a, abs_b, rem_step, quo_fix, rem_fix;
   logic        quo_bit;
   logic [63:0] ext_a, ext_b, mul_res;

   assign accept = (state_q == S_IDLE) && StartIn && is_legal_op(OpIn) && !FlushIn;
   assign a_neg  = (OpIn == OP_DIV) && OperandAIn[31];
   assign b_neg  = (OpIn == OP_DIV) && OperandBIn[31];
   assign abs_a  = a_neg ? -OperandAIn : OperandAIn;
   assign abs_b  = b_neg ? -OperandBIn : OperandBIn;

   assign quo_fix = quo_neg_q ? -a_q : a_q;
   assign rem_fix = rem_neg_q ? -rem_q : rem_q;

   div_step u_div_step (
      .rem_i          (rem_q),
      .dividend_bit_i (a_q[31]),
      .divisor_i      (b_q),
      .rem_o          (rem_step),
      .quo_bit_o      (quo_bit)
   );

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      ext_a   = (op_q == OP_MULTU) ? {32'd0, a_q} : {{32{a_q[31]}}, a_q};
      ext_b   = (op_q == OP_MULTU) ? {32'd0, b_q} : {{32{b_q[31]}}, b_q};
      mul_res = ext_a * ext_b;
`ifdef MULDIV_MADD_EN
      if (op_q == OP_MADD) mul_res = acc_q + (ext_a * ext_b);
      if (op_q == OP_MSUB) mul_res = acc_q - (ext_a * ext_b);
`endif
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q   <= S_IDLE;
         op_q      <= '0;
         cnt_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         rem_q     <= '0;
         quo_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         dbz_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         write_q   <= 1'b0;
         dbz_out_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
`ifdef MULDIV_MADD_EN
         acc_q     <= '0;
`endif
      end else begin
         done_q    <= 1'b0;
         write_q   <= 1'b0;
         dbz_out_q <= 1'b0;
         case (state_q)
            S_IDLE: if (accept) begin
               op_q   <= OpIn;
               rem_q  <= '0;
               busy_q <= 1'b1;
               if (is_div_op(OpIn)) begin
                  a_q       <= abs_a;
                  b_q       <= abs_b;
                  quo_neg_q <= a_neg ^ b_neg;
                  rem_neg_q <= a_neg;
                  dbz_q     <= (OperandBIn == '0);
                  cnt_q     <= DIV_CNT_INIT;
                  // A zero divisor skips the iterations and only spends the fixup cycle.
                  state_q   <= (OperandBIn == '0) ? S_DIV_FIXUP : S_DIV_RUN;
               end else begin
                  a_q     <= OperandAIn;
                  b_q     <= OperandBIn;
                  dbz_q   <= 1'b0;
                  cnt_q   <= MUL_CNT_INIT;
                  state_q <= S_MUL_WAIT;
`ifdef MULDIV_MADD_EN
                  acc_q   <= {HiIn, LoIn};
`endif
               end
            end
            S_MUL_WAIT: begin
               if (FlushIn) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else if (cnt_q == '0) begin
                  hi_q    <= mul_res[63:32];
                  lo_q    <= mul_res[31:0];
                  done_q  <= 1'b1;
                  write_q <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q - 5'd1;
               end
            end
            S_DIV_RUN: begin
               if (FlushIn) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  rem_q <= rem_step;
                  a_q   <= {a_q[30:0], quo_bit};
                  if (cnt_q == '0) state_q <= S_DIV_FIXUP;
                  else             cnt_q   <= cnt_q - 5'd1;
               end
            end
            S_DIV_FIXUP: begin
               if (FlushIn) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  if (!dbz_q) begin
                     hi_q <= rem_fix;
                     lo_q <= quo_fix;
                  end
                  done_q    <= 1'b1;
                  write_q   <= !dbz_q;
                  dbz_out_q <= dbz_q;
                  state_q   <= S_DONE;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign BusyOut      = busy_q;
   assign StallOut     = busy_q | accept;
   assign DoneOut      = done_q;
   assign HiLoWriteOut = write_q;
   assign DivByZeroOut = dbz_out_q;
   assign HiOut        = hi_q;
   assign LoOut        = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases plus random ops
// compared against a plain-arithmetic HI/LO reference model.
module tb_muldiv_sequencer;

   localparam int MULT_LAT = 4;
   localparam logic [2:0] T_MULT = 3'd0, T_MULTU = 3'd1, T_DIV = 3'd2,
                          T_DIVU = 3'd3, T_MADD = 3'd4, T_MSUB = 3'd5;

   logic        Clk = 1'b0;
   logic        Reset, StartIn, FlushIn;
   logic [2:0]  OpIn;
   logic [31:0] OperandAIn, OperandBIn, HiIn, LoIn;
   logic        BusyOut, StallOut, DoneOut, HiLoWriteOut, DivByZeroOut;
   logic [31:0] HiOut, LoOut;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   muldiv_sequencer #(.MULT_LATENCY(MULT_LAT)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .StartIn      (StartIn),
      .OpIn         (OpIn),
      .OperandAIn   (OperandAIn),
      .OperandBIn   (OperandBIn),
      .HiIn         (HiIn),
      .LoIn         (LoIn),
      .FlushIn      (FlushIn),
      .BusyOut      (BusyOut),
      .StallOut     (StallOut),
      .DoneOut      (DoneOut),
      .HiLoWriteOut (HiLoWriteOut),
      .DivByZeroOut (DivByZeroOut),
      .HiOut        (HiOut),
      .LoOut        (LoOut)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference result {HI,LO} from the architectural definition of each op.
   function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] hi,
                                              input logic [31:0] lo);
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      longint unsigned ua = 64'(a);
      longint unsigned ub = 64'(b);
      case (op)
         T_MULT:  return 64'(sa * sb);
         T_MULTU: return 64'(ua * ub);
         T_DIV:   return {32'(sa % sb), 32'(sa / sb)};
         T_DIVU:  return {32'(ua % ub), 32'(ua / ub)};
         T_MADD:  return {hi, lo} + 64'(sa * sb);
         default: return {hi, lo} - 64'(sa * sb);
      endcase
   endfunction

   // Starts at a negedge with the DUT idle; returns at a negedge after DONE.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                         input bit hold);
      bit          is_div = (op == T_DIV) || (op == T_DIVU);
      bit          dbz    = is_div && (b == 32'd0);
      int          lat    = dbz ? 1 : (is_div ? 33 : MULT_LAT);
      logic [63:0] expv   = dbz ? {exp_hi, exp_lo} : ref_result(op, a, b, hi, lo);
      int          n      = 0;
      bit          seen   = 1'b0;
      StartIn = 1'b1; OpIn = op; OperandAIn = a; OperandBIn = b;
      HiIn = hi; LoIn = lo; FlushIn = 1'b0;
      #1 check({tag, "_stall_accept"}, StallOut, 1);
      @(posedge Clk);
      @(negedge Clk);
      if (!hold) StartIn = 1'b0;
      check({tag, "_busy_after_accept"}, BusyOut, 1);
      while (!seen && n < 100) begin
         @(posedge Clk);
         n++;
         @(negedge Clk);
         if (DoneOut === 1'b1) seen = 1'b1;
         else check({tag, "_stall_running"}, StallOut, 1);
      end
      check({tag, "_done_seen"}, seen, 1);
      check({tag, "_latency"}, n, lat);
      check({tag, "_write"}, HiLoWriteOut, !dbz);
      check({tag, "_dbz"}, DivByZeroOut, dbz);
      check({tag, "_stall_done"}, StallOut, 1);
      check({tag, "_hi"}, HiOut, expv[63:32]);
      check({tag, "_lo"}, LoOut, expv[31:0]);
      StartIn = 1'b0;
      exp_hi = expv[63:32];
      exp_lo = expv[31:0];
      @(posedge Clk);
      @(negedge Clk);
      check({tag, "_idle_busy"}, BusyOut, 0);
      check({tag, "_idle_done"}, DoneOut, 0);
      check({tag, "_hold_hi"}, HiOut, exp_hi);
   endtask

   // Presents a request that must not be accepted and confirms nothing starts.
   task automatic reject_op(input string tag, input logic [2:0] op, input logic flush);
      StartIn = 1'b1; OpIn = op; OperandAIn = 32'd9; OperandBIn = 32'd3; FlushIn = flush;
      #1 check({tag, "_stall"}, StallOut, 0);
      @(posedge Clk);
      @(negedge Clk);
      check({tag, "_busy"}, BusyOut, 0);
      StartIn = 1'b0; FlushIn = 1'b0;
      @(posedge Clk);
      @(negedge Clk);
      check({tag, "_still_idle"}, BusyOut, 0);
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      bit          done_seen;

      Reset = 1'b0; StartIn = 1'b0; FlushIn = 1'b0; OpIn = '0;
      OperandAIn = '0; OperandBIn = '0; HiIn = '0; LoIn = '0;
      repeat (2) @(negedge Clk);
      check("reset_busy", BusyOut, 0);
      check("reset_done", DoneOut, 0);
      check("reset_hilo", {HiOut, LoOut}, 64'd0);
      Reset = 1'b1;
      @(negedge Clk);

      run_op("mult_neg3x7", T_MULT, 32'hFFFF_FFFD, 32'd7, 32'd0, 32'd0, 1'b1);
      check("plan_mult_hi", HiOut, 32'hFFFF_FFFF);
      check("plan_mult_lo", LoOut, 32'hFFFF_FFEB);
      run_op("divu_100_7", T_DIVU, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0);
      check("plan_divu_lo", LoOut, 32'd14);
      check("plan_divu_hi", HiOut, 32'd2);
      run_op("div_m7_2", T_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 1'b0);
      check("plan_div_lo", LoOut, 32'hFFFF_FFFD);
      check("plan_div_hi", HiOut, 32'hFFFF_FFFF);
      run_op("div_min_m1", T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0);
      check("plan_wrap_lo", LoOut, 32'h8000_0000);
      check("plan_wrap_hi", HiOut, 32'd0);
      run_op("divu_by_zero", T_DIVU, 32'd5, 32'd0, 32'd0, 32'd0, 1'b0);
      check("plan_dbz_keep_lo", LoOut, 32'h8000_0000);
      run_op("multu_max", T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0);

      reject_op("illegal_op7", 3'd7, 1'b0);
      reject_op("flush_with_start", T_MULT, 1'b1);
`ifdef MULDIV_MADD_EN
      run_op("madd_carry", T_MADD, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0);
      check("plan_madd_hi", HiOut, 32'd1);
      check("plan_madd_lo", LoOut, 32'd0);
      run_op("msub_neg", T_MSUB, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd10, 1'b0);
`else
      reject_op("madd_disabled", T_MADD, 1'b0);
`endif

      // Flush a divide in flight, then start a new op right after.
      StartIn = 1'b1; OpIn = T_DIV; OperandAIn = 32'd1000; OperandBIn = 32'd3; FlushIn = 1'b0;
      @(posedge Clk);
      @(negedge Clk);
      StartIn = 1'b0;
      done_seen = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge Clk);
         @(negedge Clk);
         done_seen |= DoneOut;
      end
      FlushIn = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      FlushIn = 1'b0;
      done_seen |= DoneOut;
      check("flush_idle", BusyOut, 0);
      check("flush_no_done", done_seen, 0);
      check("flush_keep_hi", HiOut, exp_hi);
      run_op("after_flush", T_DIVU, 32'd77, 32'd5, 32'd0, 32'd0, 1'b0);

      for (int i = 0; i < 14; i++) begin
`ifdef MULDIV_MADD_EN
         rop = 3'($urandom_range(0, 5));
`else
         rop = 3'($urandom_range(0, 3));
`endif
         ra = $urandom;
         case ($urandom_range(0, 7))
            0:       rb = 32'd0;
            1, 2:    rb = $urandom_range(1, 15);
            3:       rb = -32'($urandom_range(1, 15));
            default: rb = $urandom;
         endcase
         run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, $urandom, $urandom, 1'b0);
      end

      // Reset in the middle of a divide clears everything at once.
      run_op("pre_reset", T_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 32'd0, 1'b0);
      StartIn = 1'b1; OpIn = T_DIV; OperandAIn = 32'd50; OperandBIn = 32'd7;
      @(posedge Clk);
      @(negedge Clk);
      StartIn = 1'b0;
      repeat (5) @(posedge Clk);
      #2 Reset = 1'b0;
      #1;
      check("midreset_busy", BusyOut, 0);
      check("midreset_stall", StallOut, 0);
      check("midreset_strobes", {DoneOut, HiLoWriteOut, DivByZeroOut}, 0);
      check("midreset_hilo", {HiOut, LoOut}, 64'd0);
      exp_hi = '0;
      exp_lo = '0;
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      run_op("post_reset_dbz", T_DIV, 32'd3, 32'd0, 32'd0, 32'd0, 1'b0);
      run_op("post_reset_mult", T_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'd0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
